alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX issue stage that drives the ALU: decodes an RV32I instruction into the 4-bit ALU
//  Operation code, selects SrcA/SrcB and registers them in one EX pipeline register.
//  Valid/ready on both sides; supports stall (ex_ready=0) and flush. Issue counter for perf.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width
//  OPCODE_LENGTH  4   ALU Operation width
//  CNT_WIDTH      16  issued-op counter width
// PORTS
//  clk         in   1              clock, rising edge
//  reset       in   1              async, active-low (0 = reset)
//  in_valid    in   1              decode-side instr valid
//  in_ready    out  1              stage can accept
//  instr       in   32             RV32I instruction word
//  rs1_data    in   DATA_WIDTH     rs1 register value
//  rs2_data    in   DATA_WIDTH     rs2 register value
//  flush       in   1              kill EX-register contents (branch redirect)
//  ex_valid    out  1              EX register holds an op
//  ex_ready    in   1              ALU/EX consumer accepts this cycle
//  SrcA, SrcB  out  DATA_WIDTH     ALU operands (registered)
//  Operation   out  OPCODE_LENGTH  ALU op code (registered)
//  rd          out  5              destination register (registered)
//  reg_write   out  1              op writes rd (0 for branches, stores, illegal)
//  is_branch   out  1              op is a conditional branch compare
//  illegal     out  1              unsupported encoding; Operation=4'b1111 (ALU yields 0)
//  issue_cnt   out  CNT_WIDTH      count of ops handed to EX; wraps
// BEHAVIOUR
//  - Reset: ex_valid=0, SrcA=SrcB=0, Operation=0, rd=0, reg_write/is_branch/illegal=0, issue_cnt=0.
//  - in_ready = !ex_valid || ex_ready (combinational). Accept = in_valid && in_ready; latency 1.
//  - Stall: ex_valid && !ex_ready -> all EX outputs hold; no accept.
//  - Handoff = ex_valid && ex_ready: issue_cnt++ (wraps to 0 at max).
//  - flush: next ex_valid=0, any simultaneous accept discarded; a handoff in same cycle counts.
//  - Decode (funct3, funct7[5]) -> Operation, SrcB; SrcA=rs1_data unless noted:
//    R 0110011: 000/0 ADD 0100, 000/1 SUB 0010, 111 AND 0000, 110 OR 0011, 100 XOR 0001,
//      010 SLT 1110; SrcB=rs2_data.
//    I 0010011: 000 ADDI 0100, 010 SLTI 1110, 001 SLLI 1001, 101/0 SRLI 1100, 101/1 SRAI 0111;
//      SrcB=sext(instr[31:20]) -> SRAI SrcB = 1024+shamt (ALU removes the 1024 bias).
//    LUI 0110111: 1010, SrcB={instr[31:12],12'b0}, SrcA=0.
//    LOAD 0000011 / STORE 0100011: ADD 0100, SrcB=sext I-/S-imm; STORE reg_write=0.
//    BRANCH 1100011: 000 BEQ 1000, 001 BNE 0110, 100 BLT 1101, 101 BGE 0101;
//      SrcB=rs2_data, is_branch=1, reg_write=0.
//    Anything else, incl. R funct7 not 0/0x20: illegal=1, Operation=1111, reg_write=0.
//  - rd=instr[11:7] for all; rd==0 forces reg_write=0.
//  - Reset mid-operation: pending EX op dropped, counter cleared, no partial state.
// STRUCTURE
//  - Package alu_pkg: ALU op localparams (ALU_AND..ALU_SRAI, ALU_NOP=4'b1111), RV opcode consts,
//    typedef struct ex_bundle_t {SrcA,SrcB,Operation,rd,reg_write,is_branch,illegal}.
//  - Sub-module alu_op_decoder (combinational instr+operands -> ex_bundle_t); this module holds
//    the valid/ready register, flush and counter.
// TESTING
//  - ADD x3,x1,x2 (rs1=5,rs2=7), ex_ready=1 -> next cycle Operation=0100,SrcA=5,SrcB=7,rd=3,reg_write=1.
//  - SRAI x4,x1,3 -> Operation=0111, SrcB=1027; ALU(SrcA=0xFFFFFF00) gives 0xFFFFFFE0.
//  - Hold ex_ready=0 3 cycles with in_valid=1 -> in_ready=0, outputs stable, issue_cnt unchanged.
//  - flush with in_valid=1 same cycle -> ex_valid=0 next cycle, instruction lost, in_ready=1.
//  - BNE rs1=1,rs2=2 -> Operation=0110,is_branch=1,reg_write=0; opcode 1110011 -> illegal=1, op=1111.
//  - Drive 65536 handoffs -> issue_cnt wraps to 0; reset low mid-stream -> ex_valid=0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcodes and the EX-stage bundle for the ALU issue path.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_BGE  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_BNE  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SRAI = 4'b0111;
  localparam logic [OP_W-1:0] ALU_BEQ  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SLLI = 4'b1001;
  localparam logic [OP_W-1:0] ALU_LUI  = 4'b1010;
  localparam logic [OP_W-1:0] ALU_SRLI = 4'b1100;
  localparam logic [OP_W-1:0] ALU_BLT  = 4'b1101;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b1110;
  localparam logic [OP_W-1:0] ALU_NOP  = 4'b1111;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [OP_W-1:0] Operation;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_branch;
    logic            illegal;
  } ex_bundle_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Purpose: RV32I instruction + operands -> ALU op code, operands and writeback flags.
// Latency: combinational.
// Backpressure: none; the issue stage decides when the result is captured.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output ex_bundle_t      bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       writes;
  logic       branch;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    legal     = 1'b1;
    writes    = 1'b1;
    branch    = 1'b0;
    bundle    = '0;
    bundle.SrcA      = rs1_data;
    bundle.SrcB      = rs2_data;
    bundle.Operation = ALU_NOP;
    bundle.rd        = instr[11:7];

    case (opcode)
      OPC_R: begin
        if (funct7 != 7'h00 && funct7 != 7'h20) begin
          legal = 1'b0;
        end else begin
          case (funct3)
            3'b000:  bundle.Operation = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b111:  bundle.Operation = ALU_AND;
            3'b110:  bundle.Operation = ALU_OR;
            3'b100:  bundle.Operation = ALU_XOR;
            3'b010:  bundle.Operation = ALU_SLT;
            default: legal = 1'b0;
          endcase
        end
      end
      OPC_I: begin
        // SRAI keeps funct7[5] in imm[10], so SrcB carries a +1024 bias the ALU strips
        bundle.SrcB = sext12(instr[31:20]);
        case (funct3)
          3'b000:  bundle.Operation = ALU_ADD;
          3'b010:  bundle.Operation = ALU_SLT;
          3'b001:  bundle.Operation = ALU_SLLI;
          3'b101:  bundle.Operation = funct7[5] ? ALU_SRAI : ALU_SRLI;
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        bundle.SrcA      = '0;
        bundle.SrcB      = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
        bundle.Operation = ALU_LUI;
      end
      OPC_LOAD: begin
        bundle.SrcB      = sext12(instr[31:20]);
        bundle.Operation = ALU_ADD;
      end
      OPC_STORE: begin
        bundle.SrcB      = sext12({instr[31:25], instr[11:7]});
        bundle.Operation = ALU_ADD;
        writes           = 1'b0;
      end
      OPC_BRANCH: begin
        branch = 1'b1;
        writes = 1'b0;
        case (funct3)
          3'b000:  bundle.Operation = ALU_BEQ;
          3'b001:  bundle.Operation = ALU_BNE;
          3'b100:  bundle.Operation = ALU_BLT;
          3'b101:  bundle.Operation = ALU_BGE;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      bundle.Operation = ALU_NOP;
    end
    bundle.illegal   = !legal;
    bundle.is_branch = legal && branch;
    bundle.reg_write = legal && writes && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Purpose: ID->EX issue stage; decodes RV32I into an ALU op and registers it in the EX register.
// Latency: 1 cycle from accept to ex_valid.
// Backpressure: in_ready = !ex_valid || ex_ready; EX register holds while the consumer stalls.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int OPCODE_LENGTH = OP_W,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     flush,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [4:0]               rd,
  output logic                     reg_write,
  output logic                     is_branch,
  output logic                     illegal,
  output logic [CNT_WIDTH-1:0]     issue_cnt
);

  ex_bundle_t dec;
  ex_bundle_t ex_q;
  logic       accept;
  logic       handoff;

  alu_op_decoder u_dec (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (dec)
  );

  assign in_ready = !ex_valid || ex_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = ex_valid && ex_ready;

  // flush wins over a same-cycle accept; payload may go stale since ex_valid gates it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_q     <= dec;
    end else if (handoff) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt <= '0;
    end else if (handoff) begin
      issue_cnt <= issue_cnt + CNT_WIDTH'(1);
    end
  end

  assign SrcA      = ex_q.SrcA;
  assign SrcB      = ex_q.SrcB;
  assign Operation = ex_q.Operation;
  assign rd        = ex_q.rd;
  assign reg_write = ex_q.reg_write;
  assign is_branch = ex_q.is_branch;
  assign illegal   = ex_q.illegal;

endmodule
